// File: rtl/parking_pkg.sv
// Shared types and sizing helpers for the parking lot controller, display and debouncers.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2
  } gate_state_e;

  localparam int DEF_CLK_F    = 40_000_000;
  localparam int DEF_CAPACITY = 8;

  function automatic int cnt_width(input int capacity);
    return $clog2(capacity + 1);
  endfunction

  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Gate-open interval timer: restarts from zero on start, pulses done at count GATE_CYCLES-1.
module gate_timer
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = 2 * DEF_CLK_F
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  output logic done
);

  localparam int            TW   = timer_width(GATE_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);

  logic [TW-1:0] timer;
  logic          running;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer   <= '0;
      running <= 1'b0;
    end else if (start) begin
      timer   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (timer == LAST) running <= 1'b0;
      else               timer   <= timer + TW'(1);
    end
  end

  // Combinational from registers so the FSM closes the gate on the terminal-count edge.
  assign done = running && (timer == LAST);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lot gate sequencer: captures debounced entry/exit pulses, tracks occupancy,
// and opens the barrier for a fixed interval per accepted car.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | gate closed; evaluate one pending request per cycle
//   OPEN_IN  | gate open for an arriving car, waiting for timer done
//   OPEN_OUT | gate open for a departing car, waiting for timer done
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CLK_F       = DEF_CLK_F,
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int GATE_CYCLES = CLK_F * 2,
  parameter int CNT_W       = cnt_width(CAPACITY)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             entry_pulse,
  input  logic             exit_pulse,
  output logic [CNT_W-1:0] occupancy,
  output logic [CNT_W-1:0] free_spaces,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             gate_dir,
  output logic             reject
);

  localparam logic [CNT_W-1:0] CAP_V  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CAP_M1 = CNT_W'(CAPACITY - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  gate_state_e state;
  logic        pend_in;
  logic        pend_out;
  logic        idle;
  logic        grant_in;
  logic        grant_out;
  logic        reject_in;
  logic        reject_out;
  logic        timer_start;
  logic        timer_done;

  // Exit wins in IDLE since it frees space; only one request is decided per cycle.
  assign idle        = (state == IDLE);
  assign grant_out   = idle && pend_out && !empty;
  assign reject_out  = idle && pend_out && empty;
  assign grant_in    = idle && !pend_out && pend_in && !full;
  assign reject_in   = idle && !pend_out && pend_in && full;
  assign timer_start = grant_in || grant_out;

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gate_timer (
    .CLK  (CLK),
    .RST  (RST),
    .start(timer_start),
    .done (timer_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      pend_in     <= 1'b0;
      pend_out    <= 1'b0;
      occupancy   <= '0;
      free_spaces <= CAP_V;
      full        <= 1'b0;
      empty       <= 1'b1;
      gate_open   <= 1'b0;
      gate_dir    <= 1'b0;
      reject      <= 1'b0;
    end else begin
      reject   <= reject_in || reject_out;
      // A new pulse on the consuming edge keeps the flag set.
      pend_in  <= entry_pulse || (pend_in && !(grant_in || reject_in));
      pend_out <= exit_pulse || (pend_out && !(grant_out || reject_out));

      case (state)
        IDLE: begin
          if (grant_out) begin
            state       <= OPEN_OUT;
            occupancy   <= occupancy - ONE;
            free_spaces <= free_spaces + ONE;
            full        <= 1'b0;
            empty       <= (occupancy == ONE);
            gate_open   <= 1'b1;
            gate_dir    <= 1'b0;
          end else if (grant_in) begin
            state       <= OPEN_IN;
            occupancy   <= occupancy + ONE;
            free_spaces <= free_spaces - ONE;
            full        <= (occupancy == CAP_M1);
            empty       <= 1'b0;
            gate_open   <= 1'b1;
            gate_dir    <= 1'b1;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (timer_done) begin
            state     <= IDLE;
            gate_open <= 1'b0;
            gate_dir  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
          gate_dir  <= 1'b0;
        end
      endcase
    end
  end

  a_occ_bound: assert property (@(posedge CLK) disable iff (RST) occupancy <= CAP_V);

endmodule
